// File: rtl/tx_frame_arbiter.sv
// Frame-granular 2:1 arbiter merging two TX byte FIFOs into one FIFO-style view for RMII.
// Define TX_ARB_STATS_EN to add per-source completed-frame counters (frame0_count/frame1_count).
module tx_frame_arbiter #(
    parameter int unsigned MAX_BYTES = 1536
) (
    input  logic        REF_CLK,
    input  logic        arst_n,
    input  logic        s0_aempty,
    input  logic        s0_empty,
    input  logic        s0_eod,
    input  logic [7:0]  s0_dout,
    output logic        s0_rden,
    input  logic        s1_aempty,
    input  logic        s1_empty,
    input  logic        s1_eod,
    input  logic [7:0]  s1_dout,
    output logic        s1_rden,
    output logic        m_aempty,
    output logic        m_empty,
    output logic        m_eod,
    output logic [7:0]  m_dout,
    input  logic        m_rden,
    input  logic        arb_mode,
    output logic [1:0]  grant,
`ifdef TX_ARB_STATS_EN
    output logic [15:0] frame0_count,
    output logic [15:0] frame1_count,
`endif
    output logic [15:0] drop_count
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StXfer  = 2'b01,
        StDrain = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [10:0] cnt_q, cnt_d;
    logic [15:0] drop_q, drop_d;
    logic        last_q, last_d;   // 1: source 1 was served last

    logic        req0, req1, pick0;
    logic        g_empty, g_aempty, g_eod;
    logic [7:0]  g_dout;
    logic        overlen;
    logic        pop;

    assign req0 = ~s0_aempty;
    assign req1 = ~s1_aempty;

    assign g_empty  = grant_q[1] ? s1_empty  : s0_empty;
    assign g_aempty = grant_q[1] ? s1_aempty : s0_aempty;
    assign g_eod    = grant_q[1] ? s1_eod    : s0_eod;
    assign g_dout   = grant_q[1] ? s1_dout   : s0_dout;

    assign overlen = (32'(cnt_q) >= MAX_BYTES);

    // Round-robin favours the source not served last; fixed mode always favours source 0.
    assign pick0 = arb_mode ? req0 : (req0 & (~req1 | last_q));

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        drop_d   = drop_q;
        last_d   = last_q;
        pop      = 1'b0;
        m_empty  = 1'b1;
        m_aempty = 1'b1;
        m_eod    = 1'b0;
        m_dout   = 8'h00;

        case (state_q)
            StIdle: begin
                if (req0 | req1) begin
                    grant_d = pick0 ? 2'b01 : 2'b10;
                    cnt_d   = '0;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                m_dout   = g_dout;
                m_eod    = g_eod;
                m_aempty = g_aempty;
                m_empty  = g_empty | overlen;
                pop      = m_rden & ~g_empty & ~overlen;
                if (pop && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 11'd1;
                end
                if (pop && g_eod) begin
                    state_d = StIdle;
                    grant_d = '0;
                    last_d  = grant_q[1];
                end else if (overlen || g_empty) begin
                    state_d = StDrain;
                    drop_d  = drop_q + 16'd1;
                end
            end
            StDrain: begin
                // Discard the rest of the frame as fast as the source supplies it.
                pop = ~g_empty;
                if (pop && g_eod) begin
                    state_d = StIdle;
                    grant_d = '0;
                    last_d  = grant_q[1];
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    assign s0_rden    = pop & grant_q[0];
    assign s1_rden    = pop & grant_q[1];
    assign grant      = grant_q;
    assign drop_count = drop_q;

    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            last_q  <= last_d;
        end
    end

`ifdef TX_ARB_STATS_EN
    logic [15:0] f0_q, f1_q;
    logic        fin;

    assign fin = (state_q == StXfer) & pop & g_eod;

    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            f0_q <= '0;
            f1_q <= '0;
        end else begin
            if (fin && grant_q[0]) f0_q <= f0_q + 16'd1;
            if (fin && grant_q[1]) f1_q <= f1_q + 16'd1;
        end
    end

    assign frame0_count = f0_q;
    assign frame1_count = f1_q;
`endif

endmodule
